// File: rtl/rr_delay_sched_if.sv
// Requester-side bundle for rr_delay_sched: run control, requests, grants,
// completions and status.
interface rr_delay_sched_if #(
  parameter int N = 4
);
  localparam int OW = $clog2(N + 1);

  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [N-1:0]  done;
  logic [OW-1:0] outstanding;
  logic          busy;
  logic          drained;

  modport master (
    output en, req,
    input  gnt, gnt_vld, done, outstanding, busy, drained
  );

  modport slave (
    input  en, req,
    output gnt, gnt_vld, done, outstanding, busy, drained
  );
endinterface

// File: rtl/rr_delay_sched.sv
// Round-robin scheduler for a shared fixed-latency resource: one-hot grants,
// per-requester done pulses exactly DELAY cycles later, run/drain control.
module rr_delay_sched #(
  parameter int N     = 4,
  parameter int DELAY = 3
) (
  input logic           clk,
  input logic           rst,
  rr_delay_sched_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic          r_gnt_vld;
  logic [N-1:0]  r_pipe [DELAY];
  logic [OW-1:0] r_out, w_out_nxt;
  logic          r_busy, r_drained;
  logic [N-1:0]  w_blk, w_elig, w_pend, w_done_nxt;
  logic          w_found, w_drain_done;
  logic [31:0]   w_idx;

  // Pipe stage DELAY-2 becomes the done output at the next edge.
  if (DELAY > 1) begin : g_done_pipe
    assign w_done_nxt = r_pipe[DELAY-2];
  end else begin : g_done_direct
    assign w_done_nxt = r_gnt;
  end

  always_comb begin
    // Block covers grants of the current cycle and the previous DELAY-2 cycles.
    w_blk = '0;
    if (DELAY > 1) w_blk = r_gnt;
    for (int unsigned k = 0; k + 2 < unsigned'(DELAY); k++) w_blk |= r_pipe[k];

    w_pend = r_gnt;
    for (int unsigned k = 0; k + 1 < unsigned'(DELAY); k++) w_pend |= r_pipe[k];

    w_elig    = bus.req & ~w_blk;
    w_gnt_nxt = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    if (r_state == RUN) begin
      for (int unsigned off = 0; off < unsigned'(N); off++) begin
        w_idx = (32'(r_ptr) + off) % unsigned'(N);
        if (!w_found && w_elig[PW'(w_idx)]) begin
          w_found               = 1'b1;
          w_gnt_nxt[PW'(w_idx)] = 1'b1;
          w_ptr_nxt             = PW'((w_idx + 1) % unsigned'(N));
        end
      end
    end

    case ({|w_gnt_nxt, |w_done_nxt})
      2'b10:   w_out_nxt = r_out + OW'(1);
      2'b01:   w_out_nxt = r_out - OW'(1);
      default: w_out_nxt = r_out;
    endcase

    w_state_nxt  = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      IDLE:  if (bus.en) w_state_nxt = RUN;
      RUN:   if (!bus.en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (bus.en) begin
          w_state_nxt = RUN;
        end else if (r_out == '0 && w_pend == '0) begin
          w_state_nxt  = IDLE;
          w_drain_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_out     <= '0;
      r_busy    <= 1'b0;
      r_drained <= 1'b0;
      for (int unsigned k = 0; k < unsigned'(DELAY); k++) r_pipe[k] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= |w_gnt_nxt;
      r_out     <= w_out_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_drained <= w_drain_done;
      r_pipe[0] <= r_gnt;
      for (int unsigned k = 1; k < unsigned'(DELAY); k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.gnt_vld     = r_gnt_vld;
  assign bus.done        = r_pipe[DELAY-1];
  assign bus.outstanding = r_out;
  assign bus.busy        = r_busy;
  assign bus.drained     = r_drained;
endmodule

// File: tb/tb_rr_delay_sched.sv
// Randomized and directed bench for rr_delay_sched against a cycle-level
// reference model built from grant timestamps and a completion queue.
module tb_rr_delay_sched;
  localparam int N     = 4;
  localparam int DELAY = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_delay_sched_if #(.N(N)) bus ();
  rr_delay_sched #(.N(N), .DELAY(DELAY)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: mode 0=IDLE 1=RUN 2=DRAIN
  int       m_mode;
  int       m_ptr;
  int       m_last [N];
  int       q_t [$];
  int       q_i [$];
  logic [N-1:0] e_gnt, e_done;
  int       e_out;
  bit       e_busy, e_drained;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_ptr  = 0;
    for (int i = 0; i < N; i++) m_last[i] = -1000;
    q_t.delete();
    q_i.delete();
    e_gnt = '0; e_done = '0; e_out = 0; e_busy = 0; e_drained = 0;
  endtask

  task automatic model_step(input bit en_s, input logic [N-1:0] req_s);
    int g;
    int idx;
    int old_q;
    cyc++;
    old_q     = q_t.size();
    e_gnt     = '0;
    e_done    = '0;
    e_drained = 0;
    if (q_t.size() > 0 && q_t[0] + DELAY == cyc) begin
      e_done[q_i[0]] = 1'b1;
      void'(q_t.pop_front());
      void'(q_i.pop_front());
    end
    if (m_mode == 1) begin
      g = -1;
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr + off) % N;
        if (g < 0 && req_s[idx] && (cyc - m_last[idx] >= DELAY)) g = idx;
      end
      if (g >= 0) begin
        e_gnt[g]  = 1'b1;
        m_last[g] = cyc;
        m_ptr     = (g + 1) % N;
        q_t.push_back(cyc);
        q_i.push_back(g);
      end
    end
    case (m_mode)
      0: if (en_s) m_mode = 1;
      1: if (!en_s) m_mode = 2;
      default: begin
        if (en_s) m_mode = 1;
        else if (old_q == 0) begin
          m_mode    = 0;
          e_drained = 1;
        end
      end
    endcase
    e_out  = q_t.size();
    e_busy = (m_mode != 0);
  endtask

  task automatic check_outputs();
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("gnt_vld", 32'(bus.gnt_vld), 32'(|e_gnt));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("outstanding", 32'(bus.outstanding), e_out);
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("drained", 32'(bus.drained), 32'(e_drained));
    chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_vld"}, 32'(bus.gnt_vld), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_out"}, 32'(bus.outstanding), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_drained"}, 32'(bus.drained), 0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit en_v, input logic [N-1:0] req_v);
    bus.en  = en_v;
    bus.req = req_v;
    @(posedge clk);
    model_step(en_v, req_v);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic mid_reset(input string tag);
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    bus.en  = 1'b0;
    bus.req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [N-1:0] rr_seq [5];
  int           out_seq [5];

  initial begin
    rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    out_seq = '{1, 2, 3, 3, 3};
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Single requester: grants every DELAY cycles
    cycle(1'b1, 4'b0001);
    repeat (11) cycle(1'b1, 4'b0001);

    // All requesting: strict rotation, outstanding saturates at DELAY
    mid_reset("rst_a");
    cycle(1'b1, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'b1111);
      chk("rr_seq", 32'(bus.gnt), 32'(rr_seq[k]));
      chk("rr_out", 32'(bus.outstanding), out_seq[k]);
    end
    repeat (6) cycle(1'b1, 4'b1111);

    // Drain with two grants in flight
    mid_reset("rst_b");
    repeat (3) cycle(1'b1, 4'b0011);
    chk("drain_pre_out", 32'(bus.outstanding), 2);
    repeat (6) cycle(1'b0, 4'b0011);
    chk("drain_busy", 32'(bus.busy), 0);
    chk("drain_out", 32'(bus.outstanding), 0);

    // Async reset with three grants outstanding
    mid_reset("rst_c");
    repeat (4) cycle(1'b1, 4'b1111);
    chk("pre_rst_out", 32'(bus.outstanding), 3);
    mid_reset("rst_mid");
    repeat (DELAY + 2) cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b1111);
    chk("post_rst_gnt", 32'(bus.gnt), 32'd1);

    // Random traffic with occasional drains and resets
    mid_reset("rst_d");
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) mid_reset("rst_rand");
      else cycle($urandom_range(0, 9) != 0, N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
